// File: rtl/uart_lsb_embedder_if.sv
// Bundle for the serial input, message input and the byte/frame outputs of the LSB embedder.
// The master drives the line and the message; the slave (the design) returns the received data.
interface uart_lsb_embedder_if #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 1
);
  logic                      in_rx_serial;
  logic [FRAME_SIZE-1:0]     in_message;
  logic [7:0]                out_rx_byte;
  logic                      out_rx_valid;
  logic [FRAME_SIZE*BPS-1:0] out_frame;
  logic                      out_ready;

  modport master (
    output in_rx_serial, in_message,
    input  out_rx_byte, out_rx_valid, out_frame, out_ready
  );

  modport slave (
    input  in_rx_serial, in_message,
    output out_rx_byte, out_rx_valid, out_frame, out_ready
  );
endinterface

// File: rtl/uart_lsb_embedder.sv
// 8N1 UART receiver feeding a little-endian frame packer whose completed frame
// has the LSB of every sample replaced by one message bit.
module uart_lsb_embedder #(
  parameter int CLKS_PER_BIT = 87,
  parameter int BPS          = 16,
  parameter int FRAME_SIZE   = 1
) (
  input logic                  in_clk,
  input logic                  in_rst,
  uart_lsb_embedder_if.slave   bus
);
  localparam int FW     = FRAME_SIZE * BPS;
  localparam int NBYTES = FW / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMR_W  = $clog2(CLKS_PER_BIT);
  localparam int HALF   = (CLKS_PER_BIT - 1) / 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;

  logic             rx_meta, rx_sync;
  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       rx_byte;
  logic             rx_valid;

  logic [CNT_W-1:0] byte_cnt;
  logic [FW-1:0]    frame_buf;
  logic [FW-1:0]    full_frame;
  logic [FW-1:0]    embedded;
  logic [FW-1:0]    frame;
  logic             ready;

  // Synchronizer resets to the idle level so leaving reset never looks like a start bit.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.in_rx_serial;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          timer   <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (timer == TMR_W'(HALF)) begin
            timer <= '0;
            state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DATA: begin
          if (timer == TMR_W'(CLKS_PER_BIT - 1)) begin
            timer          <= '0;
            shift[bit_idx] <= rx_sync;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_STOP: begin
          if (timer == TMR_W'(CLKS_PER_BIT - 1)) begin
            timer <= '0;
            state <= S_CLEANUP;
            // A low stop bit is a framing error: the byte is dropped silently.
            if (rx_sync) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_CLEANUP: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every always_comb target gets a full default first so no latch is inferred.
  always_comb begin
    full_frame = frame_buf;
    full_frame[byte_cnt*8 +: 8] = rx_byte;
    embedded = full_frame;
    for (int i = 0; i < FRAME_SIZE; i++) embedded[i*BPS] = bus.in_message[i];
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      byte_cnt  <= '0;
      frame_buf <= '0;
      frame     <= '0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (rx_valid) begin
        frame_buf[byte_cnt*8 +: 8] <= rx_byte;
        if (byte_cnt == CNT_W'(NBYTES - 1)) begin
          byte_cnt <= '0;
          frame    <= embedded;
          ready    <= 1'b1;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_rx_byte  = rx_byte;
  assign bus.out_rx_valid = rx_valid;
  assign bus.out_frame    = frame;
  assign bus.out_ready    = ready;
endmodule

// File: tb/tb_uart_lsb_embedder.sv
// Randomized bench for uart_lsb_embedder: serial stimulus is scored against a
// queue-based model of the byte stream and the embedded frames it should produce.
module tb_uart_lsb_embedder;
  localparam int CPB        = 87;
  localparam int BPS        = 16;
  localparam int FRAME_SIZE = 1;
  localparam int FW         = FRAME_SIZE * BPS;
  localparam int NBYTES     = FW / 8;

  logic clk;
  logic rst;

  uart_lsb_embedder_if #(.BPS(BPS), .FRAME_SIZE(FRAME_SIZE)) bus ();

  uart_lsb_embedder #(.CLKS_PER_BIT(CPB), .BPS(BPS), .FRAME_SIZE(FRAME_SIZE)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]    exp_bytes[$];
  logic [7:0]    obs_bytes[$];
  logic [FW-1:0] exp_frames[$];
  logic [FW-1:0] obs_frames[$];
  logic [7:0]    part[$];
  logic [FW-1:0] last_frame;
  logic          prev_ready;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: bytes arrive in order, NBYTES of them form a frame little-endian,
  // then sample i's bit 0 is forced to message bit i.
  task automatic model_byte(input logic [7:0] b);
    logic [FW-1:0] f;
    exp_bytes.push_back(b);
    part.push_back(b);
    if (part.size() == NBYTES) begin
      f = '0;
      for (int k = 0; k < NBYTES; k++) f[8*k +: 8] = part[k];
      for (int i = 0; i < FRAME_SIZE; i++) f[i*BPS] = bus.in_message[i];
      exp_frames.push_back(f);
      last_frame = f;
      part.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_rx_valid) obs_bytes.push_back(bus.out_rx_byte);
      if (bus.out_ready) begin
        obs_frames.push_back(bus.out_frame);
        check("ready_single_cycle", 64'(prev_ready), 64'd0);
      end
      prev_ready = bus.out_ready;
    end else begin
      prev_ready = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    bus.in_rx_serial = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.in_rx_serial = b[i];
      repeat (CPB) @(posedge clk);
    end
    bus.in_rx_serial = stop_ok;
    repeat (CPB) @(posedge clk);
    bus.in_rx_serial = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b);
  endtask

  task automatic finish_test(input string tag);
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check({tag, "_byte_count"}, 64'(obs_bytes.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < exp_bytes.size(); i++)
      if (i < obs_bytes.size()) check({tag, "_byte"}, 64'(obs_bytes[i]), 64'(exp_bytes[i]));
    check({tag, "_frame_count"}, 64'(obs_frames.size()), 64'(exp_frames.size()));
    for (int i = 0; i < exp_frames.size(); i++)
      if (i < obs_frames.size()) check({tag, "_frame"}, 64'(obs_frames[i]), 64'(exp_frames[i]));
    check({tag, "_frame_hold"}, 64'(bus.out_frame), 64'(last_frame));
    exp_bytes.delete();
    obs_bytes.delete();
    exp_frames.delete();
    obs_frames.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_byte"}, 64'(bus.out_rx_byte), 64'd0);
    check({tag, "_rx_valid"}, 64'(bus.out_rx_valid), 64'd0);
    check({tag, "_frame"}, 64'(bus.out_frame), 64'd0);
    check({tag, "_ready"}, 64'(bus.out_ready), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.in_rx_serial = 1'b1;
    bus.in_message   = '0;
    last_frame       = '0;
    prev_ready       = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    rst = 1'b0;
    repeat (CPB) @(posedge clk);

    bus.in_message = 1'b1;
    send_good(8'h3F);
    send_good(8'hFF);
    finish_test("t1");
    check("t1_frame_value", 64'(bus.out_frame), 64'hFF3F);

    bus.in_message = 1'b0;
    send_good(8'h01);
    send_good(8'hF0);
    finish_test("t2");
    check("t2_upper_bits", 64'(bus.out_frame[FW-1:1]), 64'h7800);

    bus.in_message = 1'b1;
    send_good(8'hFE);
    send_good(8'h12);
    finish_test("t3a");
    send_good(8'h00);
    send_good(8'h00);
    finish_test("t3b");
    check("t3_frame_value", 64'(bus.out_frame), 64'h0001);

    // Short low pulse on the idle line must be rejected at the mid-start recheck.
    bus.in_rx_serial = 1'b0;
    repeat (20) @(posedge clk);
    bus.in_rx_serial = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    bus.in_message = 1'b0;
    send_good(8'hA5);
    send_good(8'h5A);
    finish_test("t4");

    bus.in_message = 1'b1;
    send_good(8'h34);
    send_byte(8'h77, 1'b0);
    repeat (CPB) @(posedge clk);
    send_good(8'h12);
    finish_test("t5");

    bus.in_message = 1'b0;
    send_good(8'h3F);
    repeat (CPB) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("t6_in_reset");
    @(posedge clk);
    rst = 1'b0;
    part.delete();
    last_frame = '0;
    repeat (CPB) @(posedge clk);
    send_good(8'h01);
    send_good(8'hF0);
    finish_test("t6");
    check("t6_frame_value", 64'(bus.out_frame), 64'hF000);

    for (int f = 0; f < 8; f++) begin
      bus.in_message = FRAME_SIZE'($urandom_range(0, 1));
      for (int b = 0; b < NBYTES; b++) begin
        if ($urandom_range(0, 5) == 0) begin
          send_byte(8'($urandom_range(0, 255)), 1'b0);
          repeat (CPB) @(posedge clk);
        end
        send_good(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2 * CPB)) @(posedge clk);
      end
      finish_test("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
